// File: rtl/banco_display_reader_pkg.sv
// Shared display constants and digit-state encoding for the bank display reader.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package banco_display_reader_pkg;

    // Active-low segment patterns, bit order gfedcba (bit 6 = g, bit 0 = a).
    localparam logic [6:0] SSEG_0     = 7'b1000000;
    localparam logic [6:0] SSEG_1     = 7'b1111001;
    localparam logic [6:0] SSEG_2     = 7'b0100100;
    localparam logic [6:0] SSEG_3     = 7'b0110000;
    localparam logic [6:0] SSEG_4     = 7'b0011001;
    localparam logic [6:0] SSEG_5     = 7'b0010010;
    localparam logic [6:0] SSEG_6     = 7'b0000010;
    localparam logic [6:0] SSEG_7     = 7'b1111000;
    localparam logic [6:0] SSEG_8     = 7'b0000000;
    localparam logic [6:0] SSEG_9     = 7'b0010000;
    localparam logic [6:0] SSEG_A     = 7'b0001000;
    localparam logic [6:0] SSEG_B     = 7'b0000011;
    localparam logic [6:0] SSEG_C     = 7'b1000110;
    localparam logic [6:0] SSEG_D     = 7'b0100001;
    localparam logic [6:0] SSEG_E     = 7'b0000110;
    localparam logic [6:0] SSEG_F     = 7'b0001110;
    localparam logic [6:0] SSEG_BLANK = 7'b1111111;

    // Active-low, one-hot-low digit anodes.
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Refresh FSM states: which digit is currently lit.
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_t;

endpackage

// File: rtl/banco_display_reader_hex_to_sseg.sv
// Hex nibble to active-low 7-segment pattern (gfedcba).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module hex_to_sseg
    import banco_display_reader_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] sseg
);

    // Straight table lookup; every nibble value has a glyph.
    always_comb begin
        sseg = SSEG_BLANK;
        unique case (hex)
            4'h0: sseg = SSEG_0;
            4'h1: sseg = SSEG_1;
            4'h2: sseg = SSEG_2;
            4'h3: sseg = SSEG_3;
            4'h4: sseg = SSEG_4;
            4'h5: sseg = SSEG_5;
            4'h6: sseg = SSEG_6;
            4'h7: sseg = SSEG_7;
            4'h8: sseg = SSEG_8;
            4'h9: sseg = SSEG_9;
            4'hA: sseg = SSEG_A;
            4'hB: sseg = SSEG_B;
            4'hC: sseg = SSEG_C;
            4'hD: sseg = SSEG_D;
            4'hE: sseg = SSEG_E;
            4'hF: sseg = SSEG_F;
        endcase
    end

endmodule

// File: rtl/banco_display_reader.sv
// Drives the register bank's two read ports (manual or auto-sweep) and shows data/addresses on a 4-digit 7-seg.
// Latency: sel change -> addr +1 cycle, data capture +2, segment output +3 (when that digit is lit).
// Backpressure: none; free-running display refresh, all outputs registered.
module banco_display_reader
    import banco_display_reader_pkg::*;
#(
    parameter int BIT_ADDR    = 3,
    parameter int BIT_DATO    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int SCAN_DWELL  = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic [BIT_ADDR-1:0] selRa,
    input  logic [BIT_ADDR-1:0] selRb,
    output logic [BIT_ADDR-1:0] addrRa,
    output logic [BIT_ADDR-1:0] addrRb,
    input  logic [BIT_DATO-1:0] datOutRa,
    input  logic [BIT_DATO-1:0] datOutRb,
    output logic [6:0]          sseg,
    output logic [3:0]          an
);

    localparam int PW = $clog2(REFRESH_DIV) + 1;
    localparam int DW = $clog2(SCAN_DWELL) + 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);

    logic                modePrev;
    logic                modeRise;
    logic [BIT_ADDR-1:0] scan;
    logic [BIT_ADDR-1:0] scanNext;
    logic [DW-1:0]       dwell;
    logic [DW-1:0]       dwellNext;
    logic [PW-1:0]       prescaler;
    digit_t              digit;
    logic [BIT_DATO-1:0] datAQ;
    logic [BIT_DATO-1:0] datBQ;
    logic [3:0]          nibble;
    logic [6:0]          segPat;

    // Next scan/dwell: a manual->auto edge restarts the sweep and beats a same-cycle terminal count.
    always_comb begin
        modeRise  = mode & ~modePrev;
        scanNext  = scan;
        dwellNext = dwell + DW'(1);
        if (modeRise) begin
            scanNext  = '0;
            dwellNext = '0;
        end else if (dwell == DWELL_LAST) begin
            scanNext  = scan + BIT_ADDR'(1);
            dwellNext = '0;
        end
    end

    // Sweep state and read-address mux; in auto mode the address tracks the scan value it is entering.
    always_ff @(posedge clk) begin
        if (rst) begin
            modePrev <= 1'b0;
            scan     <= '0;
            dwell    <= '0;
            addrRa   <= '0;
            addrRb   <= '0;
        end else begin
            modePrev <= mode;
            scan     <= scanNext;
            dwell    <= dwellNext;
            if (mode) begin
                addrRa <= scanNext;
                addrRb <= scanNext + BIT_ADDR'(1);
            end else begin
                addrRa <= selRa;
                addrRb <= selRb;
            end
        end
    end

    // Capture the bank's combinational read data one cycle after the address is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            datAQ <= '0;
            datBQ <= '0;
        end else begin
            datAQ <= datOutRa;
            datBQ <= datOutRb;
        end
    end

    // Pick the value for the currently lit digit, zero-extended to a nibble.
    always_comb begin
        nibble = 4'(datAQ);
        unique case (digit)
            DIG0:    nibble = 4'(datAQ);
            DIG1:    nibble = 4'(datBQ);
            DIG2:    nibble = 4'(addrRa);
            DIG3:    nibble = 4'(addrRb);
            default: nibble = 4'(datAQ);
        endcase
    end

    hex_to_sseg u_hex (
        .hex  (nibble),
        .sseg (segPat)
    );

    // Refresh FSM: rotate the lit digit every REFRESH_DIV cycles; anode and segments registered from the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            digit     <= DIG0;
            an        <= AN_OFF;
            sseg      <= SSEG_BLANK;
        end else begin
            if (prescaler == PRESC_LAST) begin
                prescaler <= '0;
                unique case (digit)
                    DIG0:    digit <= DIG1;
                    DIG1:    digit <= DIG2;
                    DIG2:    digit <= DIG3;
                    DIG3:    digit <= DIG0;
                    default: digit <= DIG0;
                endcase
            end else begin
                prescaler <= prescaler + PW'(1);
            end
            unique case (digit)
                DIG0:    an <= AN_DIG0;
                DIG1:    an <= AN_DIG1;
                DIG2:    an <= AN_DIG2;
                DIG3:    an <= AN_DIG3;
                default: an <= AN_OFF;
            endcase
            sseg <= segPat;
        end
    end

endmodule
